// File: rtl/peak_window_if.sv
// Signal bundle between the NIOS/sample side and the peak-window sequencer.
interface peak_window_if;
  // Strobe semantics: clk_en qualifies detection for one sys_clk cycle; abs_peak_flag,
  // peak_clr and nios_rd_peak are one-cycle pulses with no back-pressure (there is no ready).
  logic        nios_adc_on;
  logic        clk_en;
  logic        detection;
  logic        valid_peak_found;
  logic        fifo_full;
  logic        nios_rd_req;
  logic        abs_peak_flag;
  logic        peak_clr;
  logic        nios_rd_peak;
  logic [3:0]  peak_count;
  logic        overflow;
  logic [13:0] window_len;
  logic [2:0]  state;

  modport master (
    output nios_adc_on, clk_en, detection, valid_peak_found, fifo_full, nios_rd_req,
    input  abs_peak_flag, peak_clr, nios_rd_peak, peak_count, overflow, window_len, state
  );

  modport slave (
    input  nios_adc_on, clk_en, detection, valid_peak_found, fifo_full, nios_rd_req,
    output abs_peak_flag, peak_clr, nios_rd_peak, peak_count, overflow, window_len, state
  );
endinterface

// File: rtl/peak_window_ctrl.sv
// Frames DETECTION bursts into windows, commits one FIFO write per window after a hold-off,
// turns NIOS read-request edges into single FIFO pops and tracks FIFO occupancy/overflow.
module peak_window_ctrl #(
  parameter logic [4:0]  HOLDOFF = 5'd16,
  parameter logic [13:0] MAX_WIN = 14'd2048,
  parameter logic [3:0]  DEPTH   = 4'd8
) (
  input logic          sys_clk_i,
  input logic          rst_i,
  peak_window_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    WINDOW = 3'd2,
    HOLD   = 3'd3,
    COMMIT = 3'd4,
    CLEAR  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] win_cnt_q, win_cnt_d;
  logic [4:0]  hold_cnt_q, hold_cnt_d;
  logic        rd_req_q;
  logic        abs_flag_q, abs_flag_d;
  logic        peak_clr_q, peak_clr_d;
  logic        rd_peak_q, rd_peak_d;
  logic [3:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic [13:0] window_len_q, window_len_d;
  logic [13:0] win_inc;
  logic [4:0]  hold_inc;
  logic        advance;

  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    win_inc    = win_cnt_q + 14'd1;
    hold_inc   = hold_cnt_q + 5'd1;
    // COMMIT and CLEAR are single-cycle; every other state moves only on a sample strobe.
    advance    = bus.clk_en || (state_q == COMMIT) || (state_q == CLEAR);

    case (state_q)
      IDLE: begin
        if (bus.clk_en && bus.nios_adc_on) state_d = ARMED;
      end
      ARMED: begin
        if (bus.clk_en && bus.detection) begin
          state_d   = WINDOW;
          win_cnt_d = 14'd1;
        end
      end
      WINDOW: begin
        if (bus.clk_en) begin
          win_cnt_d = win_inc;
          if (win_inc == MAX_WIN) begin
            state_d = COMMIT;
          end else if (!bus.detection) begin
            state_d    = HOLD;
            hold_cnt_d = 5'd0;
          end
        end
      end
      HOLD: begin
        if (bus.clk_en) begin
          win_cnt_d = win_inc;
          if (win_inc == MAX_WIN) begin
            state_d = COMMIT;
          end else if (bus.detection) begin
            state_d = WINDOW;
          end else begin
            hold_cnt_d = hold_inc;
            if (hold_inc == HOLDOFF - 5'd1) state_d = COMMIT;
          end
        end
      end
      COMMIT: state_d = CLEAR;
      CLEAR: begin
        state_d   = ARMED;
        win_cnt_d = 14'd0;
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !bus.nios_adc_on && advance) begin
      state_d    = IDLE;
      win_cnt_d  = 14'd0;
      hold_cnt_d = 5'd0;
    end
  end

  // Commit side effects are decided on the edge that enters COMMIT, so the write strobe
  // and the new window length are both visible during the COMMIT cycle itself.
  always_comb begin
    abs_flag_d   = (state_d == COMMIT) && !bus.fifo_full;
    window_len_d = (state_d == COMMIT) ? win_cnt_d : window_len_q;
    peak_clr_d   = (state_d == CLEAR) || ((state_q == IDLE) && (state_d == ARMED));
    overflow_d   = overflow_q;
    if ((state_q == IDLE) && (state_d == ARMED)) begin
      overflow_d = 1'b0;
    end else if ((state_d == COMMIT) && bus.fifo_full) begin
      overflow_d = 1'b1;
    end

    rd_peak_d = bus.nios_rd_req && !rd_req_q && bus.valid_peak_found;

    count_d = count_q;
    if (abs_flag_d && !rd_peak_d && (count_q < DEPTH)) begin
      count_d = count_q + 4'd1;
    end else if (rd_peak_d && !abs_flag_d && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      win_cnt_q    <= 14'd0;
      hold_cnt_q   <= 5'd0;
      rd_req_q     <= 1'b0;
      abs_flag_q   <= 1'b0;
      peak_clr_q   <= 1'b0;
      rd_peak_q    <= 1'b0;
      count_q      <= 4'd0;
      overflow_q   <= 1'b0;
      window_len_q <= 14'd0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_req_q     <= bus.nios_rd_req;
      abs_flag_q   <= abs_flag_d;
      peak_clr_q   <= peak_clr_d;
      rd_peak_q    <= rd_peak_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      window_len_q <= window_len_d;
    end
  end

  assign bus.abs_peak_flag = abs_flag_q;
  assign bus.peak_clr      = peak_clr_q;
  assign bus.nios_rd_peak  = rd_peak_q;
  assign bus.peak_count    = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.window_len    = window_len_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_peak_window_ctrl.sv
// Directed + randomized bench for peak_window_ctrl; windows are predicted from the sample
// stream (first high sample, run of HOLDOFF lows, or MAX_WIN length) and FIFO occupancy.
module tb_peak_window_ctrl;
  localparam int HOLDOFF = 16;
  localparam int MAX_WIN = 2048;
  localparam int DEPTH   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  peak_window_if bus ();

  peak_window_ctrl dut (
    .sys_clk_i (clk),
    .rst_i     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int m_count = 0;
  bit m_ovf   = 1'b0;
  int m_len   = 0;
  bit force_invalid = 1'b0;
  bit force_valid   = 1'b0;
  bit force_notfull = 1'b0;
  bit gaps_on       = 1'b0;

  bit          det_q[$];
  logic [13:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit valid_m();
    return !force_invalid && (force_valid || (m_count > 0));
  endfunction

  function automatic bit full_m();
    return !force_notfull && (m_count >= DEPTH);
  endfunction

  task automatic tick();
    bus.valid_peak_found = valid_m();
    bus.fifo_full        = full_m();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_flag"},  32'(bus.abs_peak_flag), 0);
    chk({pfx, "_clr"},   32'(bus.peak_clr), 0);
    chk({pfx, "_rd"},    32'(bus.nios_rd_peak), 0);
    chk({pfx, "_count"}, 32'(bus.peak_count), 0);
    chk({pfx, "_ovf"},   32'(bus.overflow), 0);
    chk({pfx, "_len"},   32'(bus.window_len), 0);
    chk({pfx, "_state"}, 32'(bus.state), 0);
  endtask

  task automatic push(input bit v, input int n);
    repeat (n) det_q.push_back(v);
  endtask

  // One CLK_EN sample, optionally preceded by idle cycles with CLK_EN low.
  task automatic sample(input bit det, input bit rd);
    int n;
    n = gaps_on ? int'($urandom_range(0, 2)) : 0;
    repeat (n) begin
      bus.clk_en = 1'b0;
      tick();
      chk("gap_no_flag", 32'(bus.abs_peak_flag), 0);
    end
    bus.clk_en      = 1'b1;
    bus.detection   = det;
    bus.nios_rd_req = rd;
    tick();
  endtask

  // Sample index at which the window closes; len is its length in samples.
  function automatic int win_model(output int len);
    int f    = -1;
    int lows = 0;
    len = 0;
    for (int i = 0; i < det_q.size(); i++) begin
      if (f < 0) begin
        if (det_q[i]) f = i;
      end else begin
        lows = det_q[i] ? 0 : lows + 1;
        if ((lows == HOLDOFF) || (i - f + 1 == MAX_WIN)) begin
          len = i - f + 1;
          return i;
        end
      end
    end
    return -1;
  endfunction

  task automatic commit_sample(input bit det, input bit rd, input bit post_det);
    bit          exp_write;
    bit          exp_pop;
    logic [13:0] exp_len;
    exp_write = !full_m();
    exp_pop   = rd && valid_m();
    exp_len   = exp_q.pop_front();
    sample(det, rd);
    chk("commit_flag",  32'(bus.abs_peak_flag), 32'(exp_write));
    chk("commit_state", 32'(bus.state), 4);
    chk("commit_len",   32'(bus.window_len), 32'(exp_len));
    chk("commit_pop",   32'(bus.nios_rd_peak), 32'(exp_pop));
    if (exp_write && !exp_pop) m_count = (m_count < DEPTH) ? m_count + 1 : DEPTH;
    else if (exp_pop && !exp_write) m_count = (m_count > 0) ? m_count - 1 : 0;
    if (!exp_write) m_ovf = 1'b1;
    m_len = int'(exp_len);
    chk("commit_count", 32'(bus.peak_count), m_count);
    chk("commit_ovf",   32'(bus.overflow), 32'(m_ovf));
    bus.nios_rd_req = 1'b0;
    bus.clk_en      = 1'($urandom_range(0, 1));
    bus.detection   = post_det;
    tick();
    chk("clear_pulse",    32'(bus.peak_clr), 1);
    chk("flag_one_cycle", 32'(bus.abs_peak_flag), 0);
    chk("clear_state",    32'(bus.state), 5);
    tick();
    chk("rearm_state",     32'(bus.state), 1);
    chk("clear_one_cycle", 32'(bus.peak_clr), 0);
  endtask

  task automatic play_window(input bit rd, input bit post_det);
    int j;
    int len;
    j = win_model(len);
    exp_q.push_back(14'(len));
    for (int i = 0; i < j; i++) begin
      sample(det_q[i], 1'b0);
      chk("no_early_flag", 32'(bus.abs_peak_flag), 0);
    end
    commit_sample(det_q[j], rd, post_det);
  endtask

  task automatic build_random();
    det_q.delete();
    push(1'b0, int'($urandom_range(0, 4)));
    push(1'b1, int'($urandom_range(1, 6)));
    if ($urandom_range(0, 1) == 1) begin
      push(1'b0, int'($urandom_range(1, HOLDOFF - 1)));
      push(1'b1, int'($urandom_range(1, 4)));
    end
    push(1'b0, HOLDOFF + 2);
  endtask

  // Rising edge of NIOS_RD_REQ held for 1+hold_cycles cycles; at most one pop expected.
  task automatic read_rise(input int hold_cycles);
    bit exp_pop;
    exp_pop         = valid_m();
    bus.clk_en      = 1'b0;
    bus.nios_rd_req = 1'b1;
    tick();
    chk("rd_pop", 32'(bus.nios_rd_peak), 32'(exp_pop));
    if (exp_pop && (m_count > 0)) m_count--;
    chk("rd_count", 32'(bus.peak_count), m_count);
    repeat (hold_cycles) begin
      tick();
      chk("rd_single_pop", 32'(bus.nios_rd_peak), 0);
    end
    bus.nios_rd_req = 1'b0;
    tick();
    chk("rd_release", 32'(bus.nios_rd_peak), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.nios_adc_on      = 1'b0;
    bus.clk_en           = 1'b0;
    bus.detection        = 1'b0;
    bus.valid_peak_found = 1'b0;
    bus.fifo_full        = 1'b0;
    bus.nios_rd_req      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("idle_hold", 32'(bus.state), 0);

    bus.nios_adc_on = 1'b1;
    bus.clk_en      = 1'b1;
    tick();
    chk("enable_state", 32'(bus.state), 1);
    chk("enable_clr",   32'(bus.peak_clr), 1);
    bus.clk_en = 1'b0;
    tick();
    chk("enable_clr_once", 32'(bus.peak_clr), 0);

    // 10-sample burst then lows, strobe every cycle
    gaps_on = 1'b0;
    det_q.delete();
    push(1'b1, 10);
    push(1'b0, HOLDOFF + 2);
    play_window(1'b0, 1'b0);
    chk("burst10_len",   32'(bus.window_len), 26);
    chk("burst10_count", 32'(bus.peak_count), 1);

    // retrigger inside the hold-off merges into one window
    det_q.delete();
    push(1'b1, 5);
    push(1'b0, 8);
    push(1'b1, 5);
    push(1'b0, HOLDOFF + 2);
    play_window(1'b0, 1'b0);
    chk("retrig_len",   32'(bus.window_len), 34);
    chk("retrig_count", 32'(bus.peak_count), 2);

    gaps_on = 1'b1;
    repeat (3) begin
      build_random();
      play_window(1'b0, 1'b0);
    end

    read_rise(0);
    read_rise(0);
    chk("three_stored", 32'(bus.peak_count), 3);
    read_rise(19);
    chk("held_req_count", 32'(bus.peak_count), 2);

    det_q.delete();
    push(1'b1, 1);
    push(1'b0, HOLDOFF + 2);
    play_window(1'b1, 1'b0);
    chk("coincide_count", 32'(bus.peak_count), 2);

    force_invalid = 1'b1;
    read_rise(0);
    force_invalid = 1'b0;
    chk("invalid_count", 32'(bus.peak_count), 2);

    read_rise(0);
    read_rise(0);
    force_valid = 1'b1;
    read_rise(0);
    force_valid = 1'b0;
    chk("count_floor", 32'(bus.peak_count), 0);

    // DETECTION held high: forced commit at MAX_WIN, then a fresh window
    det_q.delete();
    push(1'b1, MAX_WIN + 4);
    play_window(1'b0, 1'b1);
    chk("maxwin_len", 32'(bus.window_len), 2048);
    sample(1'b1, 1'b0);
    chk("reopen_state", 32'(bus.state), 2);
    repeat (HOLDOFF - 1) begin
      sample(1'b0, 1'b0);
      chk("reopen_no_flag", 32'(bus.abs_peak_flag), 0);
    end
    exp_q.push_back(14'd17);
    commit_sample(1'b0, 1'b0, 1'b0);
    read_rise(0);
    read_rise(0);

    // nine windows, no reads: FIFO fills, ninth is dropped
    repeat (9) begin
      det_q.delete();
      push(1'b1, 1);
      push(1'b0, HOLDOFF + 2);
      play_window(1'b0, 1'b0);
    end
    chk("fill_count", 32'(bus.peak_count), 8);
    chk("fill_ovf",   32'(bus.overflow), 1);
    force_notfull = 1'b1;
    det_q.delete();
    push(1'b1, 2);
    push(1'b0, HOLDOFF + 2);
    play_window(1'b0, 1'b0);
    force_notfull = 1'b0;
    chk("count_ceiling", 32'(bus.peak_count), 8);

    bus.nios_adc_on = 1'b0;
    bus.clk_en      = 1'b1;
    tick();
    chk("off_state", 32'(bus.state), 0);
    chk("off_ovf",   32'(bus.overflow), 1);
    bus.nios_adc_on = 1'b1;
    tick();
    m_ovf = 1'b0;
    chk("reenable_ovf",   32'(bus.overflow), 0);
    chk("reenable_state", 32'(bus.state), 1);
    chk("reenable_clr",   32'(bus.peak_clr), 1);

    // abandon an open window
    sample(1'b1, 1'b0);
    sample(1'b1, 1'b0);
    sample(1'b1, 1'b0);
    chk("pre_abort_state", 32'(bus.state), 2);
    bus.nios_adc_on = 1'b0;
    bus.clk_en      = 1'b1;
    bus.detection   = 1'b1;
    tick();
    chk("abort_state", 32'(bus.state), 0);
    chk("abort_len",   32'(bus.window_len), m_len);
    chk("abort_count", 32'(bus.peak_count), m_count);
    chk("abort_ovf",   32'(bus.overflow), 32'(m_ovf));
    repeat (20) begin
      bus.clk_en    = 1'($urandom_range(0, 1));
      bus.detection = 1'($urandom_range(0, 1));
      tick();
      chk("abort_no_flag", 32'(bus.abs_peak_flag), 0);
      chk("abort_idle",    32'(bus.state), 0);
    end
    read_rise(0);
    chk("idle_read_count", 32'(bus.peak_count), 7);
    bus.nios_adc_on = 1'b1;
    bus.clk_en      = 1'b1;
    bus.detection   = 1'b0;
    tick();
    chk("rearm_after_abort", 32'(bus.state), 1);

    // asynchronous reset in the middle of a window
    repeat (5) sample(1'b1, 1'b0);
    chk("pre_rst_state", 32'(bus.state), 2);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    m_count = 0;
    m_ovf   = 1'b0;
    m_len   = 0;
    #2;
    rst = 1'b0;
    bus.detection = 1'b0;
    bus.clk_en    = 1'b1;
    repeat (30) begin
      tick();
      chk("post_rst_no_flag", 32'(bus.abs_peak_flag), 0);
    end
    chk("post_rst_state", 32'(bus.state), 1);
    chk("post_rst_len",   32'(bus.window_len), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
